// File: rtl/cdc_wr_arb_pkg.sv
// Shared types and helpers for the CDC write-side round-robin arbiter.
package cdc_wr_arb_pkg;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

  // Next round-robin position; wraps by compare so non-power-of-2 counts work.
  function automatic int unsigned rr_next(int unsigned ptr, int unsigned n);
    return (ptr >= n - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/cdc_wr_arb_if.sv
// Requester/mailbox bundle for cdc_wr_arb; req_last exists only with CDC_ARB_BURST_EN.
interface cdc_wr_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
`ifdef CDC_ARB_BURST_EN
  logic [N_REQ-1:0]    req_last;
`endif
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    grant;
  logic                wput;
  logic [DW-1:0]       wdata;
  logic                wrdy;

`ifdef CDC_ARB_BURST_EN
  modport master (
    input  req, req_data, req_last, wrdy,
    output ack, grant, wput, wdata
  );
  modport slave (
    output req, req_data, req_last, wrdy,
    input  ack, grant, wput, wdata
  );
`else
  modport master (
    input  req, req_data, wrdy,
    output ack, grant, wput, wdata
  );
  modport slave (
    output req, req_data, wrdy,
    input  ack, grant, wput, wdata
  );
`endif

endinterface

// File: rtl/cdc_wr_arb_rr_pick.sv
// Rotating-priority encoder: first set request after rr_ptr_i, wrapping modulo N_REQ.
module cdc_wr_arb_rr_pick
  import cdc_wr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    rr_ptr_i,
  output logic             valid_o,
  output logic [PW-1:0]    idx_o
);

  int unsigned pos;
  logic        found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    pos   = int'(rr_ptr_i);
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = rr_next(pos, N_REQ);
      if (!found && req_i[PW'(pos)]) begin
        found = 1'b1;
        idx_o = PW'(pos);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cdc_wr_arb.sv
// Round-robin sharing of one CDC mailbox write port between N_REQ requesters.
// Optional multi-word bursts per grant when CDC_ARB_BURST_EN is defined.
module cdc_wr_arb
  import cdc_wr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8
) (
  input logic          wclk,
  input logic          wrst_n,
  cdc_wr_arb_if.master bus
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             wput_q, wput_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
`ifdef CDC_ARB_BURST_EN
  logic             last_q, last_d;
`endif

  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic             xfer;

  cdc_wr_arb_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  assign xfer      = wput_q & bus.wrdy;
  assign bus.ack   = grant_q & {N_REQ{xfer}};
  assign bus.grant = grant_q;
  assign bus.wput  = wput_q;
  assign bus.wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    wput_d   = wput_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
`ifdef CDC_ARB_BURST_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        wput_d  = 1'b0;
        wdata_d = '0;
        if (pick_valid) begin
          state_d = StSend;
          grant_d = N_REQ'(1) << pick_idx;
          wput_d  = 1'b1;
          wdata_d = bus.req_data[pick_idx*DW +: DW];
          idx_d   = pick_idx;
`ifdef CDC_ARB_BURST_EN
          last_d  = bus.req_last[pick_idx];
`endif
        end
      end
      StSend: begin
        // Holding while wrdy=0 falls out of the defaults.
        if (xfer) begin
          state_d  = StIdle;
          grant_d  = '0;
          wput_d   = 1'b0;
          wdata_d  = '0;
          rr_ptr_d = idx_q;
`ifdef CDC_ARB_BURST_EN
          if (!last_q && bus.req[idx_q]) begin
            state_d  = StSend;
            grant_d  = grant_q;
            wput_d   = 1'b1;
            wdata_d  = bus.req_data[idx_q*DW +: DW];
            last_d   = bus.req_last[idx_q];
            rr_ptr_d = rr_ptr_q;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      wput_q   <= 1'b0;
      wdata_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= PW'(N_REQ - 1);
`ifdef CDC_ARB_BURST_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wput_q   <= wput_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef CDC_ARB_BURST_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_wr_arb.sv
// Directed vector bench for cdc_wr_arb (N_REQ=4, DW=8); burst sequence under CDC_ARB_BURST_EN.
module tb_cdc_wr_arb;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic        wrdy;
    logic [3:0]  grant;
    logic        wput;
    logic [7:0]  wdata;
    logic [3:0]  ack;
  } vec_t;

  localparam logic [31:0] DataA = 32'h44_A5_22_11;  // port3..port0
  localparam logic [31:0] DataB = 32'hFF_FF_FF_FF;

  logic wclk;
  logic wrst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  cdc_wr_arb_if #(.N_REQ(4), .DW(8)) bus ();

  cdc_wr_arb #(
    .N_REQ (4),
    .DW    (8)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic add(input logic rst_n, input logic [3:0] req, input logic [31:0] data,
                     input logic wrdy, input logic [3:0] grant, input logic wput,
                     input logic [7:0] wdata, input logic [3:0] ack);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.data = data; v.wrdy = wrdy;
    v.grant = grant; v.wput = wput; v.wdata = wdata; v.ack = ack;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] grant, input logic wput,
                            input logic [7:0] wdata, input logic [3:0] ack);
    check({tag, " grant"}, 32'(bus.grant), 32'(grant));
    check({tag, " wput"},  32'(bus.wput),  32'(wput));
    check({tag, " wdata"}, 32'(bus.wdata), 32'(wdata));
    check({tag, " ack"},   32'(bus.ack),   32'(ack));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Outputs listed per vector are those seen before the following clock edge.
    add(1, 4'b0100, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);  // single: port2
    add(1, 4'b0100, DataA, 1, 4'b0100, 1, 8'hA5, 4'b0100);
    add(1, 4'b0000, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);
    add(1, 4'b1111, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);  // rr from ptr=2
    add(1, 4'b1111, DataA, 1, 4'b1000, 1, 8'h44, 4'b1000);
    add(1, 4'b1111, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);
    add(1, 4'b1111, DataA, 1, 4'b0001, 1, 8'h11, 4'b0001);
    add(1, 4'b1111, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);
    add(1, 4'b1111, DataA, 1, 4'b0010, 1, 8'h22, 4'b0010);
    add(1, 4'b1111, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);
    add(1, 4'b1111, DataA, 1, 4'b0100, 1, 8'hA5, 4'b0100);
    add(1, 4'b1111, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);
    add(1, 4'b1111, DataA, 1, 4'b1000, 1, 8'h44, 4'b1000);
    add(1, 4'b0000, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);
    add(1, 4'b0001, DataA, 0, 4'b0000, 0, 8'h00, 4'b0000);  // backpressure
    for (int i = 0; i < 10; i++) begin
      // Data changes and req drop while stalled must not disturb the held word.
      add(1, (i < 5) ? 4'b0001 : 4'b0000, DataB, 0, 4'b0001, 1, 8'h11, 4'b0000);
    end
    add(1, 4'b0001, DataA, 1, 4'b0001, 1, 8'h11, 4'b0001);
    add(1, 4'b0000, DataA, 1, 4'b0000, 0, 8'h00, 4'b0000);

    // Reset held 3 cycles with all requesting.
    wrst_n       = 1'b0;
    bus.req      = 4'hF;
    bus.req_data = DataA;
    bus.wrdy     = 1'b1;
`ifdef CDC_ARB_BURST_EN
    bus.req_last = 4'b0000;
`endif
    repeat (3) @(posedge wclk);
    #1;
    check_outs("reset", 4'b0000, 1'b0, 8'h00, 4'b0000);

    foreach (vecs[i]) begin
      wrst_n       = vecs[i].rst_n;
      bus.req      = vecs[i].req;
      bus.req_data = vecs[i].data;
      bus.wrdy     = vecs[i].wrdy;
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].wput, vecs[i].wdata,
                 vecs[i].ack);
      tick();
    end

    // Reset while a word is offered and stalled; rr_ptr=0 here, so req=1001 shows the reset.
    bus.req  = 4'b0010;
    bus.wrdy = 1'b0;
    tick();
    check("midrst pre wput", 32'(bus.wput), 32'd1);
    check("midrst pre grant", 32'(bus.grant), 32'h2);
    wrst_n = 1'b0;
    tick();
    bus.wrdy = 1'b1;
    #1;
    check_outs("midrst", 4'b0000, 1'b0, 8'h00, 4'b0000);
    wrst_n  = 1'b1;
    bus.req = 4'b1001;
    tick();
    check_outs("postrst", 4'b0001, 1'b1, 8'h11, 4'b0001);
    bus.req = 4'b0000;
    tick();
    check("postrst idle grant", 32'(bus.grant), 32'h0);

`ifdef CDC_ARB_BURST_EN
    // rr_ptr=0: port1 wins, three-word burst, then port0.
    bus.req      = 4'b0011;
    bus.req_last = 4'b0000;
    tick();
    check_outs("burst w1", 4'b0010, 1'b1, 8'h22, 4'b0010);
    tick();
    bus.req_last = 4'b0010;
    #1;
    check("burst w2 grant", 32'(bus.grant), 32'h2);
    check("burst w2 ack", 32'(bus.ack), 32'h2);
    tick();
    check("burst w3 grant", 32'(bus.grant), 32'h2);
    check("burst w3 ack", 32'(bus.ack), 32'h2);
    bus.req = 4'b0001;
    tick();
    check("burst end grant", 32'(bus.grant), 32'h0);
    tick();
    check("burst next grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
